rr_arbiter4: RTL and testbench

//   Four-way round-robin arbiter for a shared resource.

---
 rtl/rr_arbiter4.sv | 112 +++++++++++
 tb/tb_rr_arbiter4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-way round-robin arbiter with grant hold until release.
// A winner is picked in IDLE by searching from the rotating pointer. Its grant is held
// until the owner pulses done or drops its request, and then the pointer moves past it.
// Optional feature: define ARB_TIMEOUT_EN to force a release after HOLD_MAX grant cycles.
// In that case timeout pulses for one cycle when gnt drops.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {StIdle, StGrant} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       rel_norm;
  logic       rel_force;

  // Rotating-priority search: first requester at or after ptr wins.
  always_comb begin
    win   = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Owner-initiated release: explicit done or request withdrawn.
  always_comb begin
    rel_norm = done | ~req[gnt_idx];
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Forced release only when nothing else is releasing, so a coinciding done stays normal.
  always_comb begin
    rel_force = !rel_norm && (hold_cnt == 8'(HOLD_MAX - 1));
  end
`else
  // No counter is built; a grant can be held indefinitely.
  always_comb begin
    rel_force = 1'b0;
  end

  assign timeout = 1'b0;
`endif

  // Arbiter FSM with registered outputs and pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= 8'd0;
      timeout   <= 1'b0;
`endif
    end else begin
      unique case (state)
        StIdle: begin
`ifdef ARB_TIMEOUT_EN
          timeout <= 1'b0;
`endif
          if (|req) begin
            gnt_idx   <= win;
            gnt       <= 4'b0001 << win;
            gnt_valid <= 1'b1;
            state     <= StGrant;
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= 8'd0;
`endif
          end
        end
        StGrant: begin
          if (rel_norm || rel_force) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            state     <= StIdle;
`ifdef ARB_TIMEOUT_EN
            timeout   <= rel_force;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= hold_cnt + 8'd1;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Testbench for rr_arbiter4: table of per-cycle vectors plus hand-written reset/timeout sequences.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter4 #(.HOLD_MAX(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] eg, input logic [1:0] ei,
                         input logic ev, input logic et);
    chk({name, ".gnt"}, gnt, eg);
    chk({name, ".gnt_idx"}, {2'b00, gnt_idx}, {2'b00, ei});
    chk({name, ".gnt_valid"}, {3'b000, gnt_valid}, {3'b000, ev});
    chk({name, ".timeout"}, {3'b000, timeout}, {3'b000, et});
  endtask

  task automatic add(input logic [3:0] r, input logic d, input logic [3:0] g,
                     input logic [1:0] i, input logic v);
    vec_t t;
    t.req = r; t.done = d; t.gnt = g; t.idx = i; t.valid = v;
    vecs.push_back(t);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rotation with all four requesting, done pulsed one cycle after each grant.
    add(4'hF, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0);
    add(4'hF, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd1, 1'b0);
    add(4'hF, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(4'hF, 1'b0, 4'b1000, 2'd3, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd3, 1'b0);
    add(4'hF, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0);  // ptr -> 1
    // Priority skip and wrap: client 2 wins, ptr=3, then 0101 wraps to client 0.
    add(4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0);  // ptr -> 3
    add(4'b0101, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(4'b0101, 1'b1, 4'b0000, 2'd0, 1'b0);  // ptr -> 1
    add(4'b0101, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(4'b0101, 1'b1, 4'b0000, 2'd2, 1'b0);  // ptr -> 3
    // Request drop: client 1 granted, req[0] toggles with no effect, then req[1] drops.
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1);
    add(4'b0001, 1'b0, 4'b0000, 2'd1, 1'b0);  // ptr -> 2
    add(4'hF, 1'b0, 4'b0100, 2'd2, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd2, 1'b0);     // ptr -> 3
    // done in IDLE is ignored; idx keeps last winner.
    add(4'h0, 1'b1, 4'b0000, 2'd2, 1'b0);
    add(4'h0, 1'b0, 4'b0000, 2'd2, 1'b0);
    add(4'hF, 1'b1, 4'b1000, 2'd3, 1'b1);
    // done together with requests: release first, re-arbitrate next IDLE cycle.
    add(4'hF, 1'b1, 4'b0000, 2'd3, 1'b0);     // ptr -> 0
    add(4'hF, 1'b0, 4'b0001, 2'd0, 1'b1);
    add(4'hF, 1'b1, 4'b0000, 2'd0, 1'b0);     // ptr -> 1

    // Reset held with all requests asserted.
    rst_n = 1'b0;
    req   = 4'hF;
    done  = 1'b0;
    #2;
    chk_all("reset_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    step();
    step();
    chk_all("reset_held", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      req  = vecs[n].req;
      done = vecs[n].done;
      step();
      chk_all($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].idx, vecs[n].valid, 1'b0);
    end

    // Async reset mid-grant: gnt drops without a clock edge; ptr returns to 0.
    req  = 4'b0100;
    done = 1'b0;
    step();
    chk_all("pre_rst_grant", 4'b0100, 2'd2, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    req   = 4'hF;
    step();
    chk_all("post_rst_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    step();
    chk_all("post_rst_rel", 4'b0000, 2'd0, 1'b0, 1'b0);  // ptr -> 1

    // Hold with done=0: forced release after 8 grant cycles only when the feature is built.
    done = 1'b0;
    req  = 4'b0010;
    step();
    chk_all("hold_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int c = 2; c <= 8; c++) begin
      step();
      chk_all($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    chk_all("timeout_drop", 4'b0000, 2'd1, 1'b0, 1'b1);
    step();
    chk_all("timeout_regrant", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int c = 2; c <= 20; c++) begin
      step();
      chk_all($sformatf("hold_c%0d", c), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
